mdio_phy_responder: RTL and testbench

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

---
 rtl/mdio_phy_responder.sv | 178 +++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// MDIO (clause 22) PHY-side management responder: decodes frames on an oversampled MDC, serves a small register map.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept a frame after any run of at least one preamble 1.
module mdio_phy_responder #(
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [4:0]  PHYAD,
    input  logic        MDC,
    input  logic        MDIO_I,
    output logic        MDIO_O,
    output logic        MDIO_T,
    input  logic [15:0] STATUS,
    output logic [15:0] CTRL,
    output logic        WR_STB,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA
);

    typedef enum logic [3:0] {IDLE, ST, OP, PA, RA, TA, RD, WR, SKIP} state_t;

    state_t      state, state_n;
    logic        mdc_s1, mdc_s2, mdc_d, mdio_s1, mdio_s2;
    logic        re, bit_i, preamble_ok;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic        op_msb, is_read, addr_match;
    logic [3:0]  pa_sh;
    logic [4:0]  ra_sh;
    logic [14:0] wd_sh;
    logic [15:0] wd_full, rd_sh, rd_mux;
    logic [15:0] scratch [4];

    assign re      = mdc_s2 & ~mdc_d;
    assign bit_i   = mdio_s2;
    assign wd_full = {wd_sh, bit_i};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign preamble_ok = (pre_cnt != 6'd0);
`else
    assign preamble_ok = (pre_cnt == 6'd32);
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d   <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= MDC;
            mdc_s2  <= mdc_s1;
            mdc_d   <= mdc_s2;
            mdio_s1 <= MDIO_I;
            mdio_s2 <= mdio_s1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= IDLE;
        else         state <= state_n;
    end

    // Read and write share TA; OP is valid only when its two bits differ (10 read, 01 write).
    always_comb begin
        state_n = state;
        if (re) begin
            case (state)
                IDLE: if (!bit_i && preamble_ok) state_n = ST;
                ST:   state_n = bit_i ? OP : IDLE;
                OP:   if (bit_cnt == 5'd1) state_n = (op_msb ^ bit_i) ? PA : IDLE;
                PA:   if (bit_cnt == 5'd4) state_n = RA;
                RA:   if (bit_cnt == 5'd4) state_n = addr_match ? TA : SKIP;
                TA: begin
                    if (is_read) begin
                        if (bit_cnt == 5'd1) state_n = RD;
                    end else if (bit_cnt == 5'd0) begin
                        if (!bit_i) state_n = IDLE;
                    end else begin
                        state_n = bit_i ? IDLE : WR;
                    end
                end
                RD:   if (bit_cnt == 5'd15) state_n = IDLE;
                WR:   if (bit_cnt == 5'd15) state_n = IDLE;
                SKIP: if (bit_cnt == 5'd17) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (ra_sh)
            5'd0:                   rd_mux = CTRL;
            5'd1:                   rd_mux = STATUS;
            5'd2:                   rd_mux = PHY_ID1;
            5'd3:                   rd_mux = PHY_ID2;
            5'd4, 5'd5, 5'd6, 5'd7: rd_mux = scratch[ra_sh[1:0]];
            default:                rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            op_msb     <= 1'b0;
            is_read    <= 1'b0;
            addr_match <= 1'b0;
            pa_sh      <= '0;
            ra_sh      <= '0;
            wd_sh      <= '0;
            rd_sh      <= '0;
            MDIO_O     <= 1'b0;
            MDIO_T     <= 1'b1;
            CTRL       <= CTRL_DEFAULT;
            WR_STB     <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= '0;
            for (int i = 0; i < 4; i++) scratch[i] <= '0;
        end else begin
            WR_STB <= 1'b0;
            if (state != IDLE) pre_cnt <= '0;
            if (re) begin
                bit_cnt <= (state_n != state) ? 5'd0 : bit_cnt + 5'd1;
                case (state)
                    IDLE: pre_cnt <= !bit_i ? 6'd0 : (pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1;
                    OP: begin
                        if (bit_cnt == 5'd0) op_msb <= bit_i;
                        else                 is_read <= op_msb;
                    end
                    PA: begin
                        pa_sh <= {pa_sh[2:0], bit_i};
                        if (bit_cnt == 5'd4) addr_match <= ({pa_sh, bit_i} == PHYAD);
                    end
                    RA: ra_sh <= {ra_sh[3:0], bit_i};
                    TA: if (is_read) begin
                        // Whole word captured at the first TA bit so nothing later can change it.
                        MDIO_T <= 1'b0;
                        if (bit_cnt == 5'd0) begin
                            MDIO_O <= 1'b0;
                            rd_sh  <= rd_mux;
                        end else begin
                            MDIO_O <= rd_sh[15];
                            rd_sh  <= {rd_sh[14:0], 1'b0};
                        end
                    end
                    RD: begin
                        if (bit_cnt == 5'd15) begin
                            MDIO_T <= 1'b1;
                            MDIO_O <= 1'b0;
                        end else begin
                            MDIO_O <= rd_sh[15];
                            rd_sh  <= {rd_sh[14:0], 1'b0};
                        end
                    end
                    WR: begin
                        wd_sh <= wd_full[14:0];
                        if (bit_cnt == 5'd15) begin
                            WR_STB  <= 1'b1;
                            WR_ADDR <= ra_sh;
                            WR_DATA <= wd_full;
                            if (ra_sh == 5'd0)
                                CTRL <= wd_full[15] ? CTRL_DEFAULT : wd_full;
                            else if (ra_sh[4:2] == 3'b001)
                                scratch[ra_sh[1:0]] <= wd_full;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged MDC/MDIO frames with hand-computed expectations.
module tb_mdio_phy_responder;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [4:0]  PHYAD = 5'd5;
    logic        MDC = 1'b0;
    logic        MDIO_I = 1'b1;
    logic        MDIO_O, MDIO_T;
    logic [15:0] STATUS = 16'h796D;
    logic [15:0] CTRL;
    logic        WR_STB;
    logic [4:0]  WR_ADDR;
    logic [15:0] WR_DATA;

    int tests = 0;
    int fails = 0;
    int stb_cycles = 0;
    int t_low_cycles = 0;
    logic samp_t, samp_o;
    logic [15:0] exp_q[$];

    mdio_phy_responder dut (
        .CLK(CLK), .RESETN(RESETN), .PHYAD(PHYAD), .MDC(MDC), .MDIO_I(MDIO_I),
        .MDIO_O(MDIO_O), .MDIO_T(MDIO_T), .STATUS(STATUS), .CTRL(CTRL),
        .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WR_STB === 1'b1) stb_cycles++;
        if (MDIO_T !== 1'b1) t_low_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One MDC period (8 CLKs); the line is sampled just before the rising edge.
    task automatic mdio_bit(input logic b);
        MDIO_I = b;
        MDC = 1'b0;
        repeat (4) @(negedge CLK);
        samp_t = MDIO_T;
        samp_o = MDIO_O;
        MDC = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mdio_bit(v[i]);
    endtask

    task automatic header(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
        repeat (pre) mdio_bit(1'b1);
        send_bits(32'b01, 2);
        send_bits({30'd0, op}, 2);
        send_bits({27'd0, pa}, 5);
        send_bits({27'd0, ra}, 5);
    endtask

    task automatic read_frame(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                              output logic [15:0] data, output int nlow, output logic ta_o, output logic rel);
        header(pre, 2'b10, pa, ra);
        nlow = 0;
        mdio_bit(1'b1);
        if (samp_t == 1'b0) nlow++;
        mdio_bit(1'b1);
        if (samp_t == 1'b0) nlow++;
        ta_o = samp_o;
        for (int i = 0; i < 16; i++) begin
            mdio_bit(1'b1);
            if (samp_t == 1'b0) nlow++;
            data[15-i] = samp_o;
        end
        mdio_bit(1'b1);
        if (samp_t == 1'b0) nlow++;
        rel = samp_t;
    endtask

    task automatic write_frame(input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data);
        header(32, 2'b01, 5'd5, ra);
        send_bits({30'd0, ta}, 2);
        send_bits({16'd0, data}, 16);
        mdio_bit(1'b1);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] ra, input logic [15:0] expv);
        logic [15:0] d;
        int nl;
        logic to, rl;
        exp_q.push_back(expv);
        read_frame(32, 5'd5, ra, d, nl, to, rl);
        check({tag, "_data"}, d, exp_q.pop_front());
        check({tag, "_tlow"}, nl, 17);
        check({tag, "_rel"}, rl, 1);
    endtask

    initial begin
        logic [15:0] d;
        int nl, s;
        logic to, rl;

        repeat (3) @(negedge CLK);
        check("rst_mdio_t", MDIO_T, 1);
        check("rst_mdio_o", MDIO_O, 0);
        check("rst_ctrl", CTRL, 16'h1140);
        check("rst_wr_stb", WR_STB, 0);
        check("rst_wr_addr", WR_ADDR, 0);
        check("rst_wr_data", WR_DATA, 0);
        RESETN = 1'b1;
        repeat (4) @(negedge CLK);

        read_frame(32, 5'd5, 5'd2, d, nl, to, rl);
        check("id1_data", d, 16'h0141);
        check("id1_tlow", nl, 17);
        check("id1_ta_bit", to, 0);
        check("id1_rel", rl, 1);
        rd_check("id2", 5'd3, 16'h0CC2);
        rd_check("status", 5'd1, 16'h796D);
        rd_check("scr5_rst", 5'd5, 16'h0000);

        s = stb_cycles;
        write_frame(5'd4, 2'b10, 16'hBEEF);
        check("wr4_stb", stb_cycles - s, 1);
        check("wr4_addr", WR_ADDR, 4);
        check("wr4_data", WR_DATA, 16'hBEEF);
        rd_check("scr4", 5'd4, 16'hBEEF);

        t_low_cycles = 0;
        read_frame(32, 5'd6, 5'd2, d, nl, to, rl);
        check("other_pa_tlow", t_low_cycles, 0);
        rd_check("after_skip", 5'd2, 16'h0141);

        write_frame(5'd0, 2'b10, 16'h0100);
        check("ctrl_wr", CTRL, 16'h0100);
        rd_check("ctrl_rd", 5'd0, 16'h0100);
        write_frame(5'd0, 2'b10, 16'h8000);
        check("ctrl_rst_bit", CTRL, 16'h1140);
        check("ctrl_rst_wdata", WR_DATA, 16'h8000);

        s = stb_cycles;
        write_frame(5'd4, 2'b11, 16'h1234);
        check("bad_ta_stb", stb_cycles - s, 0);
        rd_check("bad_ta_scr4", 5'd4, 16'hBEEF);

        s = stb_cycles;
        write_frame(5'd20, 2'b10, 16'h5555);
        check("unmapped_stb", stb_cycles - s, 1);
        check("unmapped_addr", WR_ADDR, 20);
        rd_check("unmapped_rd", 5'd20, 16'h0000);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        read_frame(1, 5'd5, 5'd2, d, nl, to, rl);
        check("short_pre_data", d, 16'h0141);
        check("short_pre_tlow", nl, 17);
`else
        mdio_bit(1'b0);
        t_low_cycles = 0;
        read_frame(31, 5'd5, 5'd2, d, nl, to, rl);
        check("short_pre_tlow", t_low_cycles, 0);
`endif
        rd_check("after_pre", 5'd2, 16'h0141);

        write_frame(5'd0, 2'b10, 16'h0100);
        header(32, 2'b10, 5'd5, 5'd2);
        mdio_bit(1'b1);
        mdio_bit(1'b1);
        for (int i = 0; i < 8; i++) mdio_bit(1'b1);
        MDIO_I = 1'b1;
        MDC = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_read_driving", MDIO_T, 0);
        RESETN = 1'b0;
        #1;
        check("rst_mid_mdio_t", MDIO_T, 1);
        check("rst_mid_mdio_o", MDIO_O, 0);
        check("rst_mid_ctrl", CTRL, 16'h1140);
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        rd_check("post_rst", 5'd2, 16'h0141);
        check("post_rst_ctrl", CTRL, 16'h1140);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
